// File: rtl/shift_till_one_seq_if.sv
// Operand/result bundle for the shift-till-one normaliser.
// start is a single-cycle request: it is taken only when busy is low, and done pulses for one cycle once the result is ready.
interface shift_till_one_seq_if #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
);
    logic          start;
    logic          dir;
    logic [W-1:0]  dat;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shifted;
    logic          zero;

    modport master (
        output start, dir, dat,
        input  busy, done, cnt, shifted, zero
    );

    modport slave (
        input  start, dir, dat,
        output busy, done, cnt, shifted, zero
    );
endinterface

// File: rtl/shift_till_one_seq.sv
// Shift-till-one normaliser: counts trailing (dir=0) or leading (dir=1) zeros one shift per cycle.
// o_state exposes the FSM state for debug and checkers.
module shift_till_one_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_till_one_seq_if.slave  bus,
    output logic [1:0]           o_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_shifted;
    logic [CW-1:0] r_cnt;
    logic          r_zero;
    logic          r_dir;

    logic          w_test_bit;
    logic          w_cnt_full;
    logic          w_stop;
    logic          w_load;
    logic          w_step;
    logic [W-1:0]  w_shift_val;

    assign w_test_bit  = r_dir ? r_shifted[W-1] : r_shifted[0];
    assign w_cnt_full  = (r_cnt == CW'(W));
    assign w_stop      = w_test_bit | w_cnt_full;
    assign w_shift_val = r_dir ? {r_shifted[W-2:0], 1'b0} : {1'b0, r_shifted[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_stop) begin
                    w_state_nxt = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The count saturation test (w_cnt_full) guarantees cnt stops at W for an all-zero operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shifted <= '0;
            r_cnt     <= '0;
            r_zero    <= 1'b0;
            r_dir     <= 1'b0;
        end else if (w_load) begin
            r_shifted <= bus.dat;
            r_dir     <= bus.dir;
            r_cnt     <= '0;
            r_zero    <= 1'b0;
        end else if (w_step) begin
            r_shifted <= w_shift_val;
            r_cnt     <= r_cnt + 1'b1;
        end else if (r_state == SHIFT) begin
            r_zero <= w_cnt_full;
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.cnt     = r_cnt;
    assign bus.shifted = r_shifted;
    assign bus.zero    = r_zero;
    assign o_state     = r_state;
endmodule

// File: tb/tb_shift_till_one_seq.sv
// Bench for shift_till_one_seq: reference model of zero counting plus directed and randomized operations.
module tb_shift_till_one_seq;
    logic clk;
    logic rst_n;
    logic [1:0] state8;
    logic [1:0] state16;

    int n_checks;
    int n_errors;

    shift_till_one_seq_if #(.W(8))  bus8 ();
    shift_till_one_seq_if #(.W(16)) bus16 ();

    shift_till_one_seq #(.W(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus8.slave),
        .o_state (state8)
    );

    shift_till_one_seq #(.W(16)) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus16.slave),
        .o_state (state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of shifts needed for an 8-bit operand: trailing zeros (dir=0) or leading zeros (dir=1).
    function automatic int ref_t(input logic [7:0] d, input logic dr);
        int n;
        n = 0;
        if (dr) begin
            while (n < 8 && d[7-n] == 1'b0) n++;
        end else begin
            while (n < 8 && d[n] == 1'b0) n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] ref_sh(input logic [7:0] d, input logic dr, input int k);
        return dr ? (d << k) : (d >> k);
    endfunction

    // Model state: captured operand, its shift count t, and edges elapsed since acceptance k.
    logic [7:0] m_dat;
    logic       m_dir;
    int         m_t;
    int         m_k;

    function automatic logic m_busy();
        return m_k <= m_t + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dat = 8'h00;
            m_dir = 1'b0;
            m_t   = 0;
            m_k   = 2;
        end else if (!m_busy()) begin
            if (bus8.start) begin
                m_dat = bus8.dat;
                m_dir = bus8.dir;
                m_t   = ref_t(bus8.dat, bus8.dir);
                m_k   = 0;
            end
        end else begin
            m_k = m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int kk;
            kk = (m_k < m_t) ? m_k : m_t;
            chk("m_busy", bus8.busy, m_busy());
            chk("m_done", bus8.done, (m_k == m_t + 1));
            chk("m_cnt", bus8.cnt, kk);
            chk("m_shifted", bus8.shifted, ref_sh(m_dat, m_dir, kk));
            chk("m_zero", bus8.zero, (m_t == 8) && (m_k >= m_t + 1));
        end
    end

    // Called at a negedge in SHIFT; returns the edge index at which done became visible.
    task automatic wait_done(input int e_start, input bit scramble, output int e_out, output bit seen);
        int e;
        e = e_start;
        seen = 1'b0;
        while (!seen && e < 40) begin
            if (bus8.done) begin
                seen = 1'b1;
                bus8.start = 1'b0;
            end else begin
                @(posedge clk);
                e++;
                @(negedge clk);
                if (scramble) begin
                    bus8.start = 1'($urandom_range(0, 1));
                    bus8.dat   = 8'($urandom);
                    bus8.dir   = 1'($urandom_range(0, 1));
                end
            end
        end
        e_out = e;
        if (!seen) bus8.start = 1'b0;
    endtask

    // Called at a negedge of the DONE cycle; checks the one-cycle pulse and value hold.
    task automatic check_hold(input int ecnt, input logic [7:0] esh, input logic ez);
        @(posedge clk);
        @(negedge clk);
        chk("done_width", bus8.done, 1'b0);
        chk("idle_busy", bus8.busy, 1'b0);
        chk("hold_cnt", bus8.cnt, ecnt);
        chk("hold_shifted", bus8.shifted, esh);
        chk("hold_zero", bus8.zero, ez);
    endtask

    // Called at a negedge with the block idle; ends at a negedge of the following IDLE cycle.
    task automatic run_op(input logic [7:0] d, input logic dr, input int ecnt,
                          input logic [7:0] esh, input logic ez);
        int e;
        bit seen;
        bus8.start = 1'b1;
        bus8.dat   = d;
        bus8.dir   = dr;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'($urandom_range(0, 1));
        bus8.dat   = 8'($urandom);
        bus8.dir   = 1'($urandom_range(0, 1));
        wait_done(0, 1'b1, e, seen);
        chk("done_seen", seen, 1'b1);
        chk("latency", e, ecnt + 1);
        chk("res_cnt", bus8.cnt, ecnt);
        chk("res_shifted", bus8.shifted, esh);
        chk("res_zero", bus8.zero, ez);
        check_hold(ecnt, esh, ez);
    endtask

    initial begin
        int e;
        bit seen;
        logic [7:0] d;
        logic dr;
        int t;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0;
        bus8.dat   = 8'h00;
        bus8.dir   = 1'b0;
        bus16.start = 1'b0;
        bus16.dat   = 16'h0000;
        bus16.dir   = 1'b0;

        // Reset values, and start ignored while reset is held.
        #3;
        chk("rst_busy", bus8.busy, 1'b0);
        chk("rst_done", bus8.done, 1'b0);
        chk("rst_cnt", bus8.cnt, 0);
        chk("rst_shifted", bus8.shifted, 8'h00);
        chk("rst_zero", bus8.zero, 1'b0);
        bus8.start = 1'b1;
        bus8.dat   = 8'h81;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ignored", bus8.busy, 1'b0);
        bus8.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios with hand-computed results.
        run_op(8'h05, 1'b0, 0, 8'h05, 1'b0);
        run_op(8'h10, 1'b0, 4, 8'h01, 1'b0);
        run_op(8'h16, 1'b1, 3, 8'hB0, 1'b0);
        run_op(8'h00, 1'b0, 8, 8'h00, 1'b1);
        run_op(8'h00, 1'b1, 8, 8'h00, 1'b1);
        run_op(8'h80, 1'b1, 0, 8'h80, 1'b0);
        run_op(8'h01, 1'b1, 7, 8'h80, 1'b0);

        // Second start during the operation must be ignored.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.dat   = 8'h20;
        bus8.dir   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.dat   = 8'h45;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done(2, 1'b0, e, seen);
        chk("ign_seen", seen, 1'b1);
        chk("ign_latency", e, 6);
        chk("ign_cnt", bus8.cnt, 5);
        chk("ign_shifted", bus8.shifted, 8'h01);
        check_hold(5, 8'h01, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.dat   = 8'h40;
        bus8.dir   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", bus8.busy, 1'b0);
        chk("abort_done", bus8.done, 1'b0);
        chk("abort_cnt", bus8.cnt, 0);
        chk("abort_shifted", bus8.shifted, 8'h00);
        chk("abort_zero", bus8.zero, 1'b0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus8.done, 1'b0);
        end
        run_op(8'h0A, 1'b0, 1, 8'h05, 1'b0);

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'h01 << $urandom_range(0, 7);
                default: d = 8'($urandom);
            endcase
            dr = 1'($urandom_range(0, 1));
            t = ref_t(d, dr);
            run_op(d, dr, t, ref_sh(d, dr, t), (t == 8));
        end

        // 16-bit build: single set bit at the top, trailing-zero search.
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.dat   = 16'h8000;
        bus16.dir   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.dat   = 16'h0001;
        e = 0;
        seen = 1'b0;
        while (!seen && e < 40) begin
            if (bus16.done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                e++;
                @(negedge clk);
            end
        end
        chk("w16_seen", seen, 1'b1);
        chk("w16_latency", e, 16);
        chk("w16_cnt", bus16.cnt, 15);
        chk("w16_shifted", bus16.shifted, 16'h0001);
        chk("w16_zero", bus16.zero, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("w16_done_width", bus16.done, 1'b0);
        chk("w16_hold_cnt", bus16.cnt, 15);
        chk("w16_hold_shifted", bus16.shifted, 16'h0001);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_till_one_seq.md
SHIFT_TILL_ONE_SEQ -- requirements
Module: shift_till_one_seq

Interface
REQ-001 Parameter W, default 8: data width in bits; legal values are W >= 2.
REQ-002 Parameter CW, default $clog2(W+1) (4 for W=8): width of the count output; it must hold values 0..W.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: request a search; sampled on a rising clk edge.
REQ-006 dir  input  1: search mode, sampled with start; 0 = shift right until bit 0 is 1 (trailing zeros); 1 = shift left until bit W-1 is 1 (leading zeros).
REQ-007 dat  input  W: operand, sampled only on an accepted start.
REQ-008 busy  output  1: high whenever the FSM is not in IDLE.
REQ-009 done  output  1: one-cycle completion pulse.
REQ-010 cnt  output  CW: number of shifts performed.
REQ-011 shifted  output  W: working register; holds the normalised operand at completion.
REQ-012 zero  output  1: high when the captured operand was all zeros.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE, start=1: at that edge (E0) the block SHALL load shifted<=dat, latch dir, clear cnt and zero, and enter SHIFT.
REQ-015 start SHALL be ignored in SHIFT and DONE; busy=1 in both states; an ignored start has no side effects.
REQ-016 Each SHIFT edge, let the test bit be shifted[0] (dir=0) or shifted[W-1] (dir=1).
- If test bit = 1 or cnt = W: enter DONE; shifted and cnt hold.
- Otherwise: shift one position with zero fill (logical right for dir=0, logical left for dir=1) and increment cnt by 1.
REQ-017 On entering DONE, zero SHALL be set to 1 if cnt = W, otherwise 0.
REQ-018 The block SHALL assert done only while in DONE, for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: for a result count t, done SHALL be high in the cycle after edge E(t+1); worst case is t=W, done after E(W+1).
REQ-020 cnt, shifted and zero SHALL hold their final values from DONE until the next accepted start.
REQ-021 Changes on dat or dir after E0 SHALL not affect the operation in progress.
REQ-022 cnt SHALL never exceed W and never wrap; for the all-zero operand, final cnt=W, shifted=0 and zero=1.
REQ-023 An operand whose test bit is already 1 SHALL complete with cnt=0, shifted=dat, and done after E1.
REQ-024 A start sampled in the IDLE cycle immediately after DONE SHALL be accepted, giving back-to-back throughput of one operation per t+3 cycles.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, cnt=0, shifted=0 and zero=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.
REQ-027 While rst_n is low, start SHALL be ignored.

Verification (W=8)
REQ-028 dat=0x05, dir=0, start at E0 -> done after E1, cnt=0, shifted=0x05, zero=0.
REQ-029 dat=0x10, dir=0 -> done after E5, cnt=4, shifted=0x01; then dat=0x16, dir=1 started in the IDLE cycle after that done -> cnt=3, shifted=0xB0.
REQ-030 dat=0x00, dir=0 -> done after E9, cnt=8, shifted=0x00, zero=1; busy high E0..E9 only.
REQ-031 dat=0x20, dir=0 at E0; start with dat=0x45 at E2 -> second start ignored; done after E6, cnt=5, shifted=0x01.
REQ-032 dat=0x40, dir=0 at E0; rst_n pulsed low between E3 and E4 -> all outputs 0 immediately, no done pulse; a new start with dat=0x0A, dir=0 -> cnt=1, shifted=0x05.
REQ-033 The bench SHALL check done width (exactly one cycle) and hold of cnt/shifted/zero after done in every scenario, plus a W=16 build with dat=0x8000, dir=0 -> cnt=15, shifted=0x0001.
